elevator_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller with a one-hot floor position. Latches floor

---
 rtl/elevator_pkg.sv | 24 ++
 rtl/elevator_timer.sv | 36 +++
 rtl/elevator_ctrl.sv | 158 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Shared FSM state encodings and timer sizing helper for the
//               elevator controller.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    // Enough bits to hold the larger of the two terminal counts, never zero.
    function automatic int timer_width(input int travel_cyc, input int door_cyc);
        int max_cyc;
        max_cyc = (travel_cyc > door_cyc) ? travel_cyc : door_cyc;
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_timer.sv
`default_nettype none
// ============================================================================
// Module      : elevator_timer
// Description : Clearable up-counter that wraps to zero at a programmable
//               terminal count and flags it with done.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    assign done = en && (r_count == terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr || done) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_ctrl
// Description : N-floor SCAN elevator controller with one-hot position,
//               latched request bitmap and a shared travel/door timer.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS   = 4,
    parameter int TRAVEL_CYC = 2,
    parameter int DOOR_CYC   = 3,
    parameter int HOME_FLOOR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    output logic [N_FLOORS-1:0] cur_floor,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic                arrive,
    output logic [N_FLOORS-1:0] pending
);

    localparam int                  TW            = timer_width(TRAVEL_CYC, DOOR_CYC);
    localparam logic [TW-1:0]       C_TRAVEL_TERM = TW'(TRAVEL_CYC - 1);
    localparam logic [TW-1:0]       C_DOOR_TERM   = TW'(DOOR_CYC - 1);
    localparam logic [N_FLOORS-1:0] C_ONE         = N_FLOORS'(1);
    localparam logic [N_FLOORS-1:0] C_HOME        = C_ONE << HOME_FLOOR;

    state_t              r_state, w_state_nxt;
    logic [N_FLOORS-1:0] r_floor, w_floor_nxt;
    logic [N_FLOORS-1:0] r_pending, w_pending_nxt;
    logic                r_dir_up, w_dir_nxt;
    logic                r_arrive, w_arrive_nxt;

    logic [N_FLOORS-1:0] w_below, w_above, w_req_lat, w_want;
    logic [N_FLOORS-1:0] w_ahead, w_behind, w_step_floor, w_served;
    logic                w_timer_clr, w_timer_en, w_timer_done;
    logic [TW-1:0]       w_term;

    // One-hot position minus one gives every floor beneath it.
    assign w_below   = r_floor - C_ONE;
    assign w_above   = ~(w_below | r_floor);
    assign w_req_lat = (r_state == ST_MOVE) ? req : (req & ~r_floor);
    assign w_want    = r_pending | w_req_lat;
    assign w_ahead   = r_pending & (r_dir_up ? w_above : w_below);
    assign w_behind  = r_pending & (r_dir_up ? w_below : w_above);

    always_comb begin
        w_step_floor = r_floor;
        if (r_dir_up && !r_floor[N_FLOORS-1]) begin
            w_step_floor = r_floor << 1;
        end else if (!r_dir_up && !r_floor[0]) begin
            w_step_floor = r_floor >> 1;
        end
    end

    elevator_timer #(
        .WIDTH    (TW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_timer_clr),
        .en       (w_timer_en),
        .terminal (w_term),
        .done     (w_timer_done)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir_up;
        w_arrive_nxt = 1'b0;
        w_served     = '0;
        w_timer_clr  = 1'b0;
        w_timer_en   = 1'b0;
        w_term       = C_DOOR_TERM;
        case (r_state)
            ST_IDLE: begin
                w_served = r_floor;
                if (|(req & r_floor)) begin
                    w_state_nxt = ST_DOOR;
                    w_timer_clr = 1'b1;
                end else if (|(w_want & w_above)) begin
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = ST_MOVE;
                    w_timer_clr = 1'b1;
                end else if (|(w_want & w_below)) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = ST_MOVE;
                    w_timer_clr = 1'b1;
                end
            end
            ST_MOVE: begin
                w_timer_en = 1'b1;
                w_term     = C_TRAVEL_TERM;
                if (w_timer_done) begin
                    w_floor_nxt = w_step_floor;
                    if (|(r_pending & w_step_floor)) begin
                        w_arrive_nxt = 1'b1;
                        w_served     = w_step_floor;
                        w_state_nxt  = ST_DOOR;
                    end
                end
            end
            ST_DOOR: begin
                w_timer_en = 1'b1;
                w_served   = r_floor;
                // A fresh call at this floor holds the door rather than queueing.
                if (|(req & r_floor)) begin
                    w_timer_clr = 1'b1;
                end else if (w_timer_done) begin
                    if (|w_ahead) begin
                        w_state_nxt = ST_MOVE;
                    end else if (|w_behind) begin
                        w_dir_nxt   = ~r_dir_up;
                        w_state_nxt = ST_MOVE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pending_nxt = (r_pending | w_req_lat) & ~w_served;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_floor   <= C_HOME;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
            r_arrive  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_dir_up  <= w_dir_nxt;
            r_pending <= w_pending_nxt;
            r_arrive  <= w_arrive_nxt;
        end
    end

    assign cur_floor = r_floor;
    assign dir_up    = r_dir_up;
    assign moving    = (r_state == ST_MOVE);
    assign door_open = (r_state == ST_DOOR);
    assign arrive    = r_arrive;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_ctrl
// Description : Randomised self-checking bench for elevator_ctrl against an
//               integer-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_ctrl;

    localparam int N    = 4;
    localparam int TR   = 2;
    localparam int DR   = 3;
    localparam int HOME = 0;
    localparam int NCYC = 2500;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] cur_floor;
    logic         dir_up;
    logic         moving;
    logic         door_open;
    logic         arrive;
    logic [N-1:0] pending;

    elevator_ctrl #(
        .N_FLOORS   (N),
        .TRAVEL_CYC (TR),
        .DOOR_CYC   (DR),
        .HOME_FLOOR (HOME)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .cur_floor  (cur_floor),
        .dir_up     (dir_up),
        .moving     (moving),
        .door_open  (door_open),
        .arrive     (arrive),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_bad;

    // Reference model: integer floor index, mode, elapsed-cycle counter.
    int       m_pos;
    int       m_mode;
    int       m_cnt;
    bit       m_up;
    bit       m_arr;
    bit [N-1:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_above(input bit [N-1:0] b, input int p);
        for (int i = p + 1; i < N; i++) if (b[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_below(input bit [N-1:0] b, input int p);
        for (int i = 0; i < p; i++) if (b[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_pos  = HOME;
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_up   = 1'b1;
        m_arr  = 1'b0;
        m_pend = '0;
    endtask

    task automatic model_step(input bit [N-1:0] r);
        bit [N-1:0] old;
        int nxt;
        bit ahead, behind;
        old   = m_pend;
        m_arr = 1'b0;
        case (m_mode)
            M_IDLE: begin
                m_pend        = old | r;
                m_pend[m_pos] = 1'b0;
                if (r[m_pos]) begin
                    m_mode = M_DOOR; m_cnt = 0;
                end else if (has_above(old | r, m_pos)) begin
                    m_up = 1'b1; m_mode = M_MOVE; m_cnt = 0;
                end else if (has_below(old | r, m_pos)) begin
                    m_up = 1'b0; m_mode = M_MOVE; m_cnt = 0;
                end
            end
            M_MOVE: begin
                m_pend = old | r;
                m_cnt++;
                if (m_cnt == TR) begin
                    m_cnt = 0;
                    if (m_up) nxt = (m_pos < N - 1) ? m_pos + 1 : m_pos;
                    else      nxt = (m_pos > 0) ? m_pos - 1 : m_pos;
                    if (old[nxt]) begin
                        m_pend[nxt] = 1'b0;
                        m_arr       = 1'b1;
                        m_mode      = M_DOOR;
                    end
                    m_pos = nxt;
                end
            end
            default: begin
                m_pend        = old | r;
                m_pend[m_pos] = 1'b0;
                if (r[m_pos]) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt == DR) begin
                        m_cnt  = 0;
                        ahead  = m_up ? has_above(old, m_pos) : has_below(old, m_pos);
                        behind = m_up ? has_below(old, m_pos) : has_above(old, m_pos);
                        if (ahead) begin
                            m_mode = M_MOVE;
                        end else if (behind) begin
                            m_up   = ~m_up;
                            m_mode = M_MOVE;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_floor;
        exp_floor = '0;
        exp_floor[m_pos] = 1'b1;
        chk("cur_floor", 32'(cur_floor), 32'(exp_floor));
        chk("dir_up",    32'(dir_up),    32'(m_up));
        chk("moving",    32'(moving),    32'(m_mode == M_MOVE));
        chk("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
        chk("arrive",    32'(arrive),    32'(m_arr));
        chk("pending",   32'(pending),   32'(m_pend));
        chk("onehot",    32'($onehot(cur_floor)), 32'd1);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_cur_floor"}, 32'(cur_floor), 32'(1 << HOME));
        chk({pfx, "_dir_up"},    32'(dir_up),    32'd1);
        chk({pfx, "_pending"},   32'(pending),   32'd0);
        chk({pfx, "_moving"},    32'(moving),    32'd0);
        chk({pfx, "_door_open"}, 32'(door_open), 32'd0);
        chk({pfx, "_arrive"},    32'(arrive),    32'd0);
    endtask

    bit did_mid_rst;
    bit inj_pickup;
    bit inj_reverse;

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        did_mid_rst = 1'b0;
        inj_pickup  = 1'b0;
        inj_reverse = 1'b0;
        req         = '0;
        rst_n       = 1'b1;
        model_reset();

        // Asynchronous reset seen before any clock edge.
        #1 rst_n = 1'b0;
        #2 check_reset_values("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_all();

            if (!did_mid_rst && cyc > 300 && m_mode == M_MOVE) begin
                did_mid_rst = 1'b1;
                req = '0;
                #1 rst_n = 1'b0;
                #1 check_reset_values("rst_mid_move");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end

            req = '0;
            if (cyc == 0) begin
                req = 4'b1000;
            end else if (cyc < 25 && !inj_pickup && m_pos == 1 && m_mode == M_MOVE) begin
                inj_pickup = 1'b1;
                req = 4'b0100;
            end else if (cyc == 25) begin
                req = 4'b1111;
            end else if (cyc == 55 || cyc == 57) begin
                req = 4'b0001;
            end else if (cyc == 65) begin
                req = 4'b1000;
            end else if (cyc > 65 && cyc < 100 && !inj_reverse && m_pos == 2 && m_mode == M_MOVE) begin
                inj_reverse = 1'b1;
                req = 4'b0001;
            end else if (cyc >= 100) begin
                if ($urandom_range(0, 5) == 0) req = N'($urandom_range(0, (1 << N) - 1));
            end

            @(posedge clk);
            model_step(req);
        end

        chk("mid_move_reset_reached", 32'(did_mid_rst), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
